// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared types and constants for the Z80 I/O to AXI4-Lite bridge
package z80_bus_pkg;
  localparam int Z80_ADDR_W = 8;
  localparam int Z80_DATA_W = 8;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR_DATA,
    ST_WR_RESP,
    ST_HOLD
  } state_t;
endpackage

// File: rtl/z80_io_axil_bridge_if.sv
// z80_io_axil_bridge_if: AXI4-Lite bus (32-bit address/data) with master and slave views
interface z80_io_axil_bridge_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/z80_strobe_sync.sv
// z80_strobe_sync: multi-bit flop chain for slow asynchronous strobes; resets to all-ones (inactive)
module z80_strobe_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/z80_io_axil_bridge.sv
// z80_io_axil_bridge: turns each Z80 IN/OUT cycle into one AXI4-Lite transaction,
// stretching the CPU with WAIT_N until the response (or a timeout abort) arrives.
module z80_io_axil_bridge
  import z80_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          ADDR_SHIFT     = 2,
  parameter int          SYNC_STAGES    = 2,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [Z80_ADDR_W-1:0] z80_addr,
  input  logic [Z80_DATA_W-1:0] z80_dout,
  output logic [Z80_DATA_W-1:0] z80_din,
  input  logic                  z80_iorq_n,
  input  logic                  z80_rd_n,
  input  logic                  z80_wr_n,
  input  logic                  z80_m1_n,
  output logic                  z80_wait_n,
  z80_io_axil_bridge_if.master  AXI,
  output logic                  err
);
  state_t r_state, w_next;
  logic w_iorq_n, w_rd_n, w_wr_n, w_m1_n;
  logic w_req, w_busy, w_timeout, w_abort, w_wr_done, w_unused;
  logic [31:0] r_addr, r_cnt;
  logic [Z80_DATA_W-1:0] r_wdata;
  logic [3:0] r_wstrb;
  logic r_awvalid, r_wvalid;
  z80_strobe_sync #(.WIDTH(4), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (aclk),
    .rst (areset),
    .i_d ({z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n}),
    .o_q ({w_iorq_n, w_rd_n, w_wr_n, w_m1_n})
  );
  // interrupt acknowledge (M1 low) and RD=WR=0 never start a transaction
  assign w_req     = !w_iorq_n && w_m1_n && (w_rd_n ^ w_wr_n);
  assign w_busy    = r_state inside {ST_RD_ADDR, ST_RD_DATA, ST_WR_ADDR_DATA, ST_WR_RESP};
  assign w_wr_done = (!r_awvalid || AXI.awready) && (!r_wvalid || AXI.wready);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == 32'(TIMEOUT_CYCLES - 1));
  // a handshake completing on the last counted cycle wins over the abort
  assign w_abort   = w_timeout && (
                       (r_state == ST_RD_ADDR      && !AXI.arready) ||
                       (r_state == ST_RD_DATA      && !AXI.rvalid)  ||
                       (r_state == ST_WR_ADDR_DATA && !w_wr_done)   ||
                       (r_state == ST_WR_RESP      && !AXI.bvalid));
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:         w_next = !w_req ? ST_IDLE : (!w_rd_n ? ST_RD_ADDR : ST_WR_ADDR_DATA);
      ST_RD_ADDR:      w_next = AXI.arready ? ST_RD_DATA : ST_RD_ADDR;
      ST_RD_DATA:      w_next = AXI.rvalid ? ST_HOLD : ST_RD_DATA;
      ST_WR_ADDR_DATA: w_next = w_wr_done ? ST_WR_RESP : ST_WR_ADDR_DATA;
      ST_WR_RESP:      w_next = AXI.bvalid ? ST_HOLD : ST_WR_RESP;
      ST_HOLD:         w_next = w_iorq_n ? ST_IDLE : ST_HOLD;
      default:         w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_HOLD;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_cnt     <= '0;
      z80_din   <= 8'hFF;
      err       <= 1'b0;
    end else begin
      r_cnt <= (w_busy && w_next == r_state) ? r_cnt + 32'd1 : '0;
      if (r_state == ST_IDLE && w_req) begin
        r_addr    <= BASE_ADDR + (32'(z80_addr) << ADDR_SHIFT);
        r_wdata   <= z80_dout;
        r_wstrb   <= {3'b000, w_rd_n};
        r_awvalid <= w_rd_n;
        r_wvalid  <= w_rd_n;
      end
      if (r_state == ST_WR_ADDR_DATA) begin
        r_awvalid <= r_awvalid && !AXI.awready && !w_abort;
        r_wvalid  <= r_wvalid && !AXI.wready && !w_abort;
      end
      if (r_state == ST_RD_DATA && AXI.rvalid)
        z80_din <= (AXI.rresp == AXI_RESP_OKAY) ? AXI.rdata[7:0] : 8'hFF;
      else if (w_abort && (r_state == ST_RD_ADDR || r_state == ST_RD_DATA))
        z80_din <= 8'hFF;
      err <= err || w_abort ||
             (r_state == ST_RD_DATA && AXI.rvalid && AXI.rresp != AXI_RESP_OKAY) ||
             (r_state == ST_WR_RESP && AXI.bvalid && AXI.bresp != AXI_RESP_OKAY);
    end
  assign w_unused    = ^AXI.rdata[31:8];
  assign z80_wait_n  = (r_state == ST_IDLE) || (r_state == ST_HOLD);
  assign AXI.awaddr  = r_addr;
  assign AXI.araddr  = r_addr;
  assign AXI.awprot  = 3'b000;
  assign AXI.arprot  = 3'b000;
  assign AXI.awvalid = r_awvalid;
  assign AXI.wvalid  = r_wvalid;
  assign AXI.wdata   = {24'h0, r_wdata};
  assign AXI.wstrb   = r_wstrb;
  assign AXI.bready  = r_state == ST_WR_RESP;
  assign AXI.arvalid = r_state == ST_RD_ADDR;
  assign AXI.rready  = r_state == ST_RD_DATA;
endmodule

// File: tb/tb_z80_io_axil_bridge.sv
// tb_z80_io_axil_bridge: Z80 I/O cycles against a delay-programmable AXI-Lite slave,
// checked against expected addresses, data, handshake counts and WAIT_N timing.
module tb_z80_io_axil_bridge;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int SYNC = 2;
  localparam int TO   = 16;
  logic aclk = 1'b0, areset = 1'b1;
  logic [7:0] z80_addr, z80_dout, z80_din;
  logic z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n, z80_wait_n, err;
  int cyc = 0, n_chk = 0, n_err = 0;
  z80_io_axil_bridge_if axi ();
  z80_io_axil_bridge #(.BASE_ADDR(BASE), .ADDR_SHIFT(2), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .areset(areset), .z80_addr(z80_addr), .z80_dout(z80_dout), .z80_din(z80_din),
    .z80_iorq_n(z80_iorq_n), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n), .z80_m1_n(z80_m1_n),
    .z80_wait_n(z80_wait_n), .AXI(axi), .err(err)
  );
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;
  // slave configuration (per transaction) and observations
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0] b_resp, r_resp;
  logic [31:0] r_data, got_awaddr, got_wdata, got_araddr;
  logic [3:0] got_wstrb;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  bit aw_done, w_done, b_pend, b_hs, r_pend, r_hs, any_valid;
  int n_aw, n_w, n_b, n_ar, n_r, c_aw, c_w, c_ar, hs_cyc;
  logic exp_err;
  logic [7:0] exp_din;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic arm();
    aw_wait = aw_dly; w_wait = w_dly; ar_wait = ar_dly;
    aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0; any_valid = 0;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; c_aw = 0; c_w = 0; c_ar = 0; hs_cyc = -100;
  endtask
  // AXI-Lite slave: inputs change at negedge, so a handshake lands on the following posedge
  initial begin
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0; axi.rvalid = 0;
        b_pend = 0; b_hs = 0; r_pend = 0; r_hs = 0; aw_done = 0; w_done = 0;
        continue;
      end
      if (b_hs) begin axi.bvalid = 0; b_hs = 0; b_pend = 0; end
      if (r_hs) begin axi.rvalid = 0; r_hs = 0; r_pend = 0; end
      any_valid |= axi.awvalid | axi.wvalid | axi.arvalid;
      if (b_pend && !axi.bvalid) begin
        if (b_wait == 0) begin axi.bvalid = 1; axi.bresp = b_resp; end else b_wait--;
      end
      if (axi.bvalid && axi.bready) begin b_hs = 1; n_b++; hs_cyc = cyc; end
      if (r_pend && !axi.rvalid) begin
        if (r_wait == 0) begin axi.rvalid = 1; axi.rdata = r_data; axi.rresp = r_resp; end else r_wait--;
      end
      if (axi.rvalid && axi.rready) begin r_hs = 1; n_r++; hs_cyc = cyc; end
      axi.awready = 0; axi.wready = 0; axi.arready = 0;
      if (axi.awvalid) begin
        c_aw++;
        if (aw_wait == 0) begin axi.awready = 1; n_aw++; got_awaddr = axi.awaddr; aw_done = 1; end
        else aw_wait--;
      end
      if (axi.wvalid) begin
        c_w++;
        if (w_wait == 0) begin
          axi.wready = 1; n_w++; got_wdata = axi.wdata; got_wstrb = axi.wstrb; w_done = 1;
        end else w_wait--;
      end
      if (aw_done && w_done) begin aw_done = 0; w_done = 0; b_pend = 1; b_wait = b_dly; end
      if (axi.arvalid) begin
        c_ar++;
        if (ar_wait == 0) begin axi.arready = 1; n_ar++; got_araddr = axi.araddr; r_pend = 1; r_wait = r_dly; end
        else ar_wait--;
      end
    end
  end
  task automatic z80_io(input bit wr, input logic [7:0] port, input logic [7:0] data,
                        output logic [7:0] din, output int lo, output int hi, output int t0);
    @(negedge aclk);
    z80_addr = port; z80_dout = data;
    @(negedge aclk);
    z80_iorq_n = 0; z80_m1_n = 1;
    if (wr) z80_wr_n = 0; else z80_rd_n = 0;
    t0 = cyc; lo = -1; hi = -1;
    for (int i = 0; i < 200 && hi < 0; i++) begin
      @(negedge aclk);
      if (lo < 0 && !z80_wait_n) lo = cyc;
      else if (lo >= 0 && z80_wait_n) hi = cyc;
    end
    din = z80_din;
    z80_iorq_n = 1; z80_rd_n = 1; z80_wr_n = 1;
    repeat (6) @(negedge aclk);
  endtask
  task automatic run(input bit wr, input logic [7:0] port, input logic [7:0] data,
                     input int awd, input int wd, input int bd, input int ard, input int rd,
                     input logic [1:0] resp, input logic [31:0] rdat, input string tag);
    logic [7:0] din;
    int lo, hi, t0;
    bit to;
    logic [31:0] ea;
    to = !wr && ard >= TO;
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
    b_resp = resp; r_resp = resp; r_data = rdat;
    arm();
    z80_io(wr, port, data, din, lo, hi, t0);
    ea = BASE + 32'(port) * 4;
    if (to) begin exp_err = 1; exp_din = 8'hFF; end
    else begin
      exp_err = exp_err | (resp != 2'b00);
      if (!wr) exp_din = (resp == 2'b00) ? rdat[7:0] : 8'hFF;
    end
    chk({tag, "_wait_lo"}, 32'(lo >= 0 && lo - t0 <= SYNC + 2), 1);
    chk({tag, "_wait_hi"}, 32'(hi >= 0), 1);
    if (wr) begin
      chk({tag, "_n_aw"}, n_aw, 1); chk({tag, "_n_w"}, n_w, 1); chk({tag, "_n_b"}, n_b, 1);
      chk({tag, "_n_ar"}, n_ar, 0);
      chk({tag, "_awaddr"}, got_awaddr, ea);
      chk({tag, "_wdata"}, got_wdata, {24'h0, data});
      chk({tag, "_wstrb"}, 32'(got_wstrb), 1);
      chk({tag, "_aw_cyc"}, c_aw, awd + 1);
      chk({tag, "_w_cyc"}, c_w, wd + 1);
      chk({tag, "_release"}, hi, hs_cyc + 1);
    end else if (to) begin
      chk({tag, "_n_ar"}, n_ar, 0); chk({tag, "_n_r"}, n_r, 0);
      chk({tag, "_ar_cyc"}, c_ar, TO);
      chk({tag, "_release"}, hi, lo + TO);
      chk({tag, "_arvalid"}, 32'(axi.arvalid), 0);
    end else begin
      chk({tag, "_n_ar"}, n_ar, 1); chk({tag, "_n_r"}, n_r, 1); chk({tag, "_n_aw"}, n_aw, 0);
      chk({tag, "_araddr"}, got_araddr, ea);
      chk({tag, "_ar_cyc"}, c_ar, ard + 1);
      chk({tag, "_release"}, hi, hs_cyc + 1);
    end
    chk({tag, "_din"}, 32'(din), 32'(exp_din));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_wait_idle"}, 32'(z80_wait_n), 1);
  endtask
  task automatic ignored_cycle(input logic m1, input logic rd, input logic wr, input string tag);
    bit saw_lo;
    aw_dly = 0; w_dly = 0; ar_dly = 0; arm();
    saw_lo = 0;
    @(negedge aclk);
    z80_iorq_n = 0; z80_m1_n = m1; z80_rd_n = rd; z80_wr_n = wr;
    repeat (20) begin @(negedge aclk); if (!z80_wait_n) saw_lo = 1; end
    z80_iorq_n = 1; z80_m1_n = 1; z80_rd_n = 1; z80_wr_n = 1;
    repeat (6) @(negedge aclk);
    chk({tag, "_valid"}, 32'(any_valid), 0);
    chk({tag, "_wait"}, 32'(saw_lo), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit to_reset;
    z80_addr = 0; z80_dout = 0; z80_iorq_n = 1; z80_rd_n = 1; z80_wr_n = 1; z80_m1_n = 1;
    exp_err = 0; exp_din = 8'hFF;
    repeat (3) @(negedge aclk);
    chk("rst_wait", 32'(z80_wait_n), 1); chk("rst_din", 32'(z80_din), 32'hFF);
    chk("rst_err", 32'(err), 0);
    chk("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    chk("rst_addr", axi.awaddr | axi.araddr, 0); chk("rst_wdata", axi.wdata, 0);
    chk("rst_wstrb", 32'(axi.wstrb), 0); chk("rst_prot", 32'({axi.awprot, axi.arprot}), 0);
    areset = 0;
    repeat (3) @(negedge aclk);
    run(1, 8'h00, 8'h41, 0, 0, 3, 0, 0, 2'b00, 0, "out41");
    run(0, 8'h01, 8'h00, 0, 0, 0, 5, 10, 2'b00, 32'h0000_005A, "in5a");
    run(1, 8'h7F, 8'hC3, 0, 4, 1, 0, 0, 2'b00, 0, "out_wlate");
    run(1, 8'hFF, 8'h99, 3, 0, 0, 0, 0, 2'b00, 0, "out_awlate");
    for (int i = 0; i < 24; i++) begin
      logic [1:0] rsp;
      rsp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      run(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
          $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 5), rsp, $urandom, "rnd");
    end
    run(0, 8'h10, 8'h00, 0, 0, 0, 1000, 0, 2'b00, 0, "timeout");
    run(0, 8'h22, 8'h00, 0, 0, 0, 1, 2, 2'b00, 32'hABCD_125A, "in_after_to");
    ignored_cycle(1'b0, 1'b1, 1'b1, "intack");
    ignored_cycle(1'b1, 1'b0, 1'b0, "rdwr_both");
    aw_dly = 0; w_dly = 0; b_dly = 12; arm();
    @(negedge aclk); z80_addr = 8'h05; z80_dout = 8'h66;
    @(negedge aclk); z80_iorq_n = 0; z80_m1_n = 1; z80_wr_n = 0;
    to_reset = 0;
    for (int i = 0; i < 30 && !to_reset; i++) begin @(negedge aclk); to_reset = axi.bready; end
    chk("mid_reach_wresp", 32'(to_reset), 1);
    #2 areset = 1;
    #1;
    chk("mid_wait", 32'(z80_wait_n), 1); chk("mid_err", 32'(err), 0);
    chk("mid_din", 32'(z80_din), 32'hFF);
    chk("mid_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    chk("mid_addr", axi.awaddr, 0);
    z80_iorq_n = 1; z80_wr_n = 1;
    repeat (3) @(negedge aclk);
    areset = 0; exp_err = 0; exp_din = 8'hFF;
    repeat (3) @(negedge aclk);
    run(1, 8'h06, 8'h77, 1, 2, 2, 0, 0, 2'b00, 0, "out_after_rst");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/z80_io_axil_bridge.md
Name: z80_io_axil_bridge

Overview:
- Converts Z80 I/O cycles (IN/OUT) into single-beat AXI4-Lite master transactions toward the UART wrapper's AXI slave port.
- Holds the Z80 in T-wait with WAIT_N until the AXI response returns.
- Runs entirely in the 100 MHz domain; samples the slow Z80 strobes (5 MHz) through synchronisers.
- Sits between the z80_cpu bus pins and simple_uart_wrapper.

Parameters:
- BASE_ADDR, 32'h0000_0000, AXI base address added to every port offset.
- ADDR_SHIFT, 2, left shift applied to the Z80 port number (port n -> BASE_ADDR + (n << ADDR_SHIFT)).
- SYNC_STAGES, 2, flip-flop depth on IORQ_N/RD_N/WR_N/M1_N; allowed range 2..3.
- TIMEOUT_CYCLES, 255, aclk cycles waited for any AXI handshake before abort; 0 disables the timeout.

Ports:
- aclk  in  1  100 MHz clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- z80_addr  in  8  Z80 A[7:0] (I/O port number).
- z80_dout  in  8  data driven by the CPU on OUT.
- z80_din  out  8  data returned to the CPU on IN.
- z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n  in  1 each  raw Z80 strobes, asynchronous to aclk.
- z80_wait_n  out  1  WAIT_N to the CPU; low stretches the I/O cycle.
- AXI_awaddr/awprot/awvalid/awready, AXI_wdata/wstrb/wvalid/wready, AXI_bresp/bvalid/bready: standard AXI4-Lite write channels.
- AXI_araddr/arprot/arvalid/arready, AXI_rdata/rresp/rvalid/rready: standard AXI4-Lite read channels (32-bit address and data).
- err  out  1  sticky flag; set on non-OKAY response or timeout; cleared only by reset.

Behaviour:
- Reset values:
  - z80_wait_n=1, z80_din=8'hFF, err=0.
  - All AXI valid and ready outputs 0; addresses, wdata and wstrb 0; awprot and arprot 3'b000 (constant).
- Strobe synchronisation:
  - Strobes pass SYNC_STAGES flops.
  - A request is decoded on the synchronised values: iorq=0 with m1=1.
  - Exactly one of rd/wr must be 0. RD=WR=0 or IORQ with M1=0 (interrupt acknowledge) is ignored: no AXI activity, wait_n stays 1.
- Address and data capture: z80_addr and z80_dout are captured on the request-detect cycle. They are stable by then because they precede IORQ.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, HOLD.
- IDLE:
  - On a valid request, register the address as BASE_ADDR + (addr << ADDR_SHIFT).
  - Drive z80_wait_n=0 in the next cycle; worst case is SYNC_STAGES+2 aclk cycles after IORQ_N falls.
  - Go to RD_ADDR (IN) or WR_ADDR_DATA (OUT).
- RD_ADDR:
  - arvalid=1 until arready is sampled high, then go to RD_DATA.
  - arvalid never drops before the handshake.
- RD_DATA:
  - rready=1.
  - On rvalid: z80_din <= (rresp==OKAY) ? rdata[7:0] : 8'hFF. A non-OKAY rresp sets err.
  - Go to HOLD.
- WR_ADDR_DATA:
  - awvalid and wvalid are asserted together, each dropped independently on its own ready.
  - wdata = {24'h0, dout}, wstrb = 4'b0001.
  - When both handshakes are complete (same cycle or different cycles), go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid, go to HOLD; a non-OKAY bresp sets err.
- HOLD:
  - z80_wait_n=1.
  - Stay until the synchronised iorq is 1, then go to IDLE.
  - This guarantees one AXI transaction per Z80 I/O cycle.
- z80_din holds its value until the next completed read.
- Timeout:
  - A counter is cleared on every state entry and counts while in RD_ADDR, RD_DATA, WR_ADDR_DATA or WR_RESP.
  - On reaching TIMEOUT_CYCLES: set err, return z80_din=8'hFF for reads, and go to HOLD.
  - Outstanding valids are dropped. This is a tolerated protocol abort, used only for a hung slave.
- areset mid-transaction:
  - Immediately returns all outputs to their reset values.
  - areset must be asserted together with the slave's reset.
- Z80 aborting IORQ early while waiting: impossible while wait_n=0. If it happens anyway, the AXI transaction still completes, then HOLD exits immediately.

Decomposition:
- Package z80_bus_pkg:
  - typedef for the FSM state enum.
  - AXI_RESP_OKAY = 2'b00.
  - Port-width constants Z80_ADDR_W=8, Z80_DATA_W=8.
- One sub-module, z80_strobe_sync: a parameterised SYNC_STAGES multi-bit synchroniser, reset to all-ones (inactive).

Test Plan:
- OUT (0x00),0x41 with the slave giving awready/wready the same cycle and bvalid 3 cycles later -> single AW at 0x0000_0000, wdata 0x0000_0041, wstrb 0001; wait_n low until bvalid+1, then high; err=0.
- IN (0x01) with arready delayed 5 cycles and rdata 0x0000_005A after 10 cycles -> araddr 0x0000_0004, z80_din=0x5A, wait_n released the cycle after rvalid, exactly one AR issued.
- OUT with wready arriving 4 cycles after awready -> awvalid drops after its handshake, wvalid is held until wready, then a single B phase.
- IN with the slave never asserting arready, TIMEOUT_CYCLES=16 -> after 16 cycles arvalid=0, z80_din=0xFF, err=1, wait_n=1.
- IORQ_N=0 with M1_N=0 (interrupt acknowledge) -> no AXI valid is ever asserted, wait_n stays 1.
- areset pulsed while in WR_RESP -> wait_n=1, all valid/ready outputs 0, err=0, z80_din=0xFF asynchronously; the next OUT completes normally.
